// File: rtl/sram_march_bist_if.sv
// Control/status and SRAM-pin bundle of the March C- BIST controller.
// master = the BIST controller, slave = the environment (host plus SRAM macro).
interface sram_march_bist_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int ERR_W      = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ERR_W-1:0]      err_count;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [DATA_WIDTH-1:0] fail_exp;
    logic [DATA_WIDTH-1:0] fail_got;
    logic                  csb0;
    logic                  web0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    modport master (
        input  start, dout0,
        output busy, done, pass, err_count, fail_addr, fail_exp, fail_got,
               csb0, web0, addr0, din0
    );

    modport slave (
        output start, dout0,
        input  busy, done, pass, err_count, fail_addr, fail_exp, fail_got,
               csb0, web0, addr0, din0
    );
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST for a single-port SRAM: one op per clock, dout0 checked READ_LATENCY cycles after each read.
// Status is sticky until the next start; start is ignored while busy; all outputs registered.
module sram_march_bist #(
    parameter int DATA_WIDTH   = 2,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 8
) (
    input  logic              clk0,
    input  logic              rst0,
    sram_march_bist_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int                    DRAIN_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] ONES      = '1;
    localparam logic [2:0]            LAST_ELEM = 3'd5;

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  phase_q, phase_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_WIDTH-1:0] fail_got_q, fail_got_d;

    logic                  pipe_vld_q  [READ_LATENCY];
    logic                  pipe_vld_d  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_addr_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_addr_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_exp_q  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_exp_d  [READ_LATENCY];

    logic                  down, at_end, last_op;
    logic [2:0]            nxt_elem;
    logic                  nxt_phase;
    logic [ADDR_WIDTH-1:0] nxt_addr;

    // M0 is a lone write, M5 a lone read; M1..M4 are read-then-write pairs.
    function automatic logic op_is_write(input logic [2:0] e, input logic ph);
        return (e == 3'd0) || ((e != LAST_ELEM) && ph);
    endfunction

    // Odd elements write ones and read zeros; even elements the reverse.
    function automatic logic [DATA_WIDTH-1:0] wr_data(input logic [2:0] e);
        return e[0] ? ONES : '0;
    endfunction

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        phase_d     = phase_q;
        drain_d     = drain_q;
        csb0_d      = csb0_q;
        web0_d      = web0_q;
        addr0_d     = addr0_q;
        din0_d      = din0_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        pipe_vld_d  = pipe_vld_q;
        pipe_addr_d = pipe_addr_q;
        pipe_exp_d  = pipe_exp_q;
        down        = (elem_q >= 3'd3);
        at_end      = down ? (addr0_q == '0) : (addr0_q == ADDR_MAX);
        last_op     = 1'b0;
        nxt_elem    = elem_q;
        nxt_phase   = 1'b0;
        nxt_addr    = addr0_q;

        // Read on the pins this cycle enters the compare pipe at the closing edge.
        for (int i = READ_LATENCY - 1; i > 0; i--) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
            pipe_exp_d[i]  = pipe_exp_q[i-1];
        end
        pipe_vld_d[0]  = (state_q == RUN) && !csb0_q && web0_q;
        pipe_addr_d[0] = addr0_q;
        pipe_exp_d[0]  = elem_q[0] ? '0 : ONES;

        if (pipe_vld_q[READ_LATENCY-1] && (bus.dout0 != pipe_exp_q[READ_LATENCY-1])) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (err_q == '0) begin
                fail_addr_d = pipe_addr_q[READ_LATENCY-1];
                fail_exp_d  = pipe_exp_q[READ_LATENCY-1];
                fail_got_d  = bus.dout0;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    elem_d      = 3'd0;
                    phase_d     = 1'b0;
                    csb0_d      = 1'b0;
                    web0_d      = 1'b0;
                    addr0_d     = '0;
                    din0_d      = '0;
                end
            end
            RUN: begin
                if ((elem_q != 3'd0) && (elem_q != LAST_ELEM) && !phase_q) begin
                    nxt_phase = 1'b1;
                end else if (!at_end) begin
                    nxt_addr = down ? addr0_q - ADDR_WIDTH'(1) : addr0_q + ADDR_WIDTH'(1);
                end else if (elem_q == LAST_ELEM) begin
                    last_op = 1'b1;
                end else begin
                    // Entering M3 flips the sweep to descending with no extra cycle.
                    nxt_elem = elem_q + 3'd1;
                    nxt_addr = (elem_q >= 3'd2) ? ADDR_MAX : '0;
                end

                if (last_op) begin
                    state_d = DRAIN;
                    drain_d = '0;
                    csb0_d  = 1'b1;
                    web0_d  = 1'b1;
                    addr0_d = '0;
                    din0_d  = '0;
                end else begin
                    elem_d  = nxt_elem;
                    phase_d = nxt_phase;
                    addr0_d = nxt_addr;
                    csb0_d  = 1'b0;
                    web0_d  = !op_is_write(nxt_elem, nxt_phase);
                    din0_d  = op_is_write(nxt_elem, nxt_phase) ? wr_data(nxt_elem) : '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(READ_LATENCY - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q     <= IDLE;
            elem_q      <= 3'd0;
            phase_q     <= 1'b0;
            drain_q     <= '0;
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            addr0_q     <= '0;
            din0_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_addr_q[i] <= '0;
                pipe_exp_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            phase_q     <= phase_d;
            drain_q     <= drain_d;
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_d[i];
                pipe_addr_q[i] <= pipe_addr_d[i];
                pipe_exp_q[i]  <= pipe_exp_d[i];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.fail_exp  = fail_exp_q;
    assign bus.fail_got  = fail_got_q;
    assign bus.csb0      = csb0_q;
    assign bus.web0      = web0_q;
    assign bus.addr0     = addr0_q;
    assign bus.din0      = din0_q;
endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural 16x2 SRAMs with injectable faults, expected pin ops queued at start.
module tb_sram_march_bist;
    logic clk0 = 1'b0;
    logic rst0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fault_mode = 0;
    int   dcyc;

    logic [1:0] mem  [16];
    logic [1:0] mem2 [16];
    logic [7:0] exp_q [$];

    always #5 clk0 = ~clk0;

    sram_march_bist_if #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .ERR_W(8)) bif ();
    sram_march_bist_if #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .ERR_W(2)) bif2 ();

    sram_march_bist #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .READ_LATENCY(1), .ERR_W(8)) dut (
        .clk0(clk0), .rst0(rst0), .bus(bif.master)
    );
    sram_march_bist #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .READ_LATENCY(1), .ERR_W(2)) dut_sat (
        .clk0(clk0), .rst0(rst0), .bus(bif2.master)
    );

    function automatic logic [1:0] faulty(input logic [1:0] d, input logic [3:0] a);
        case (fault_mode)
            1:       return (a == 4'd6) ? (d | 2'b01) : d;
            2:       return (a == 4'd9) ? 2'b00 : d;
            default: return d;
        endcase
    endfunction

    always @(posedge clk0) begin
        if (!bif.csb0 && !bif.web0) mem[bif.addr0] <= bif.din0;
        if (!bif.csb0 && bif.web0)  bif.dout0 <= faulty(mem[bif.addr0], bif.addr0);
    end

    // Second macro returns every read inverted.
    always @(posedge clk0) begin
        if (!bif2.csb0 && !bif2.web0) mem2[bif2.addr0] <= bif2.din0;
        if (!bif2.csb0 && bif2.web0)  bif2.dout0 <= ~mem2[bif2.addr0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    // Entry = {csb0, web0, addr0, din0}.
    task automatic push_op(input logic wr, input logic [3:0] a, input logic [1:0] d);
        exp_q.push_back({1'b0, !wr, a, wr ? d : 2'b00});
    endtask

    task automatic push_march();
        logic [3:0] a;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 16; k++) begin
                a = (e >= 3) ? 4'(15 - k) : 4'(k);
                case (e)
                    0: push_op(1'b1, a, 2'b00);
                    1: begin push_op(1'b0, a, 2'b00); push_op(1'b1, a, 2'b11); end
                    2: begin push_op(1'b0, a, 2'b00); push_op(1'b1, a, 2'b00); end
                    3: begin push_op(1'b0, a, 2'b00); push_op(1'b1, a, 2'b11); end
                    4: begin push_op(1'b0, a, 2'b00); push_op(1'b1, a, 2'b00); end
                    default: push_op(1'b0, a, 2'b00);
                endcase
            end
        end
    endtask

    // Returns the cycle (relative to C0) at which done was seen, or -1.
    task automatic run(input int rst_at, input int restart_at, output int done_cyc);
        logic [7:0] e;
        bit         ops_ok;
        exp_q.delete();
        push_march();
        bif.start  = 1'b1;
        bif2.start = 1'b1;
        tick();
        done_cyc = -1;
        ops_ok   = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bif.start  = (cyc == restart_at);
            bif2.start = (cyc == restart_at);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (ops_ok) begin
                    check($sformatf("op%0d", cyc), {bif.csb0, bif.web0, bif.addr0, bif.din0}, e);
                    ops_ok = ({bif.csb0, bif.web0, bif.addr0, bif.din0} === e);
                end
            end
            if (cyc == 0 || cyc == 160) check("busy", bif.busy, 1);
            if (cyc == 160) check("csb0_after_last", bif.csb0, 1);
            if (cyc == 100) check("pass_while_running", {bif.done, bif.pass}, 0);
            if (bif.done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == rst_at) begin
                rst0 = 1'b1;
                tick();
                rst0 = 1'b0;
                check("rst_csb0", bif.csb0, 1);
                check("rst_web0", bif.web0, 1);
                check("rst_busy", bif.busy, 0);
                check("rst_done", bif.done, 0);
                check("rst_err", bif.err_count, 0);
                return;
            end
            tick();
        end
        bif.start  = 1'b0;
        bif2.start = 1'b0;
        if (done_cyc < 0) check("done_timeout", 0, 1);
        check("busy_after_done", bif.busy, 0);
    endtask

    initial begin
        rst0       = 1'b1;
        bif.start  = 1'b0;
        bif2.start = 1'b0;
        tick();
        tick();
        check("reset_pins", {bif.csb0, bif.web0, bif.addr0, bif.din0}, 8'hC0);
        check("reset_status", {bif.busy, bif.done, bif.pass}, 0);
        check("reset_err", bif.err_count, 0);
        check("reset_fail", {bif.fail_addr, bif.fail_exp, bif.fail_got}, 0);
        rst0 = 1'b0;
        tick();

        fault_mode = 0;
        run(-1, -1, dcyc);
        check("clean_done_cycle", dcyc, 161);
        check("clean_pass", bif.pass, 1);
        check("clean_err", bif.err_count, 0);
        check("sat_err", bif2.err_count, 3);
        check("sat_pass", {bif2.done, bif2.pass}, 2'b10);
        check("sat_fail", {bif2.fail_addr, bif2.fail_exp, bif2.fail_got}, {4'd0, 2'd0, 2'd3});
        tick();
        tick();
        check("done_held", bif.done, 1);

        fault_mode = 1;
        run(-1, -1, dcyc);
        check("sa1_done_cycle", dcyc, 161);
        check("sa1_pass", bif.pass, 0);
        check("sa1_err", bif.err_count, 3);
        check("sa1_fail", {bif.fail_addr, bif.fail_exp, bif.fail_got}, {4'd6, 2'd0, 2'd1});

        fault_mode = 2;
        run(-1, -1, dcyc);
        check("sa00_pass", {bif.done, bif.pass}, 2'b10);
        check("sa00_err", bif.err_count, 2);
        check("sa00_fail", {bif.fail_addr, bif.fail_exp, bif.fail_got}, {4'd9, 2'd3, 2'd0});

        fault_mode = 0;
        run(50, -1, dcyc);
        tick();
        run(-1, -1, dcyc);
        check("post_rst_done_cycle", dcyc, 161);
        check("post_rst_pass", bif.pass, 1);

        run(-1, 20, dcyc);
        check("restart_done_cycle", dcyc, 161);
        check("restart_pass", bif.pass, 1);

        rst0       = 1'b1;
        bif.start  = 1'b1;
        bif2.start = 1'b1;
        tick();
        rst0       = 1'b0;
        bif.start  = 1'b0;
        bif2.start = 1'b0;
        check("rst_beats_start", {bif.busy, bif.csb0, bif.done}, 3'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Built-in self-test controller that sits directly upstream of the single-port 2-bit × 16-word SRAM macro.
- Drives the macro's din0/addr0/csb0/web0 pins and consumes dout0.
- Runs a March C- sequence with one memory operation per clock and compares read data in a pipelined way.
- Reports pass/fail, the first failing address/expected/actual value, and a saturating error count.

Parameters:
- DATA_WIDTH, 2, SRAM word width; the data backgrounds are all-zeros and all-ones of this width.
- ADDR_WIDTH, 4, SRAM address width; N = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from the cycle a read is presented to the cycle dout0 is compared (≥1).
- ERR_W, 8, width of the error counter.

Ports:
- clk0  in  1  Clock; shared with the SRAM macro, all logic on the rising edge.
- rst0  in  1  Reset; synchronous, active-high.
- start  in  1  Begin a test; sampled when not busy.
- busy  out  1  Test in progress.
- done  out  1  Test complete; held until the next start or reset.
- pass  out  1  Valid when done; 1 iff err_count==0.
- err_count  out  ERR_W  Number of miscompares, saturating at all-ones.
- fail_addr  out  ADDR_WIDTH  Address of the first miscompare.
- fail_exp  out  DATA_WIDTH  Expected data at the first miscompare.
- fail_got  out  DATA_WIDTH  dout0 value at the first miscompare.
- csb0  out  1  SRAM chip select, active-low.
- web0  out  1  SRAM write enable, active-low.
- addr0  out  ADDR_WIDTH  SRAM address.
- din0  out  DATA_WIDTH  SRAM write data.
- dout0  in  DATA_WIDTH  SRAM read data.

Behaviour:
- All outputs are registered.
- Reset and idle values:
  - csb0=1, web0=1, addr0=0, din0=0.
  - busy=0, done=0, pass=0, err_count=0, fail_*=0.
- States: IDLE → RUN → DRAIN → DONE.
  - IDLE/DONE + start=1 → RUN. Sticky status is cleared on the same edge.
  - RUN issues the elements below; after the last op → DRAIN.
  - DRAIN lasts READ_LATENCY cycles; then → DONE with done=1, busy=0.
- March C- elements, executed in order (⇑ = address 0..N-1, ⇓ = N-1..0):
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇓(r0)
  - Total 10N ops, i.e. 160 for N=16.
- Op timing: let cycle C0 be the cycle after start is sampled.
  - Op i is on the pins for exactly cycle C0+i, with csb0=0 and no idle gaps.
  - Write op: web0=0, din0 = background.
  - Read op: web0=1, din0=0.
  - Within a two-op element, the read and write of one address occupy consecutive cycles; the address then steps.
- busy=1 from C0 through the end of DRAIN.
- done rises at cycle C0+10N+READ_LATENCY. For READ_LATENCY=1, N=16 that is C0+161.
- csb0 returns to 1 the cycle after the last op.
- Compare: each read pushes (addr, expected) into a READ_LATENCY-deep shift pipe. dout0 is compared at cycle read+READ_LATENCY.
- On a miscompare:
  - err_count increments, saturating at all-ones (no wrap).
  - fail_addr/exp/got are captured only on the first miscompare of the run.
- Address counter wraps within each element. Direction changes take effect at the M2→M3 boundary with no extra cycle.
- start while busy: ignored; the sequence and status are unaffected.
- Reset mid-run: on the next edge, all outputs return to reset values and the compare pipe is flushed, so in-flight reads are not compared. The SRAM contents are left as they are.
- rst0 and start asserted together: rst0 wins.
- pass is 0 whenever done=0.

Test Plan:
- Fault-free 16×2 model, start pulse.
  - Cycles C0..C0+15: web0=0, addr 0..15, din0=0.
  - C0+16: read addr 0. C0+17: write addr 0, din0=3.
  - done at C0+161, pass=1, err_count=0.
- Bit 0 of address 6 stuck-at-1.
  - done=1, pass=0, err_count=3 (r0 fails in M1, M3, M5).
  - fail_addr=6, fail_exp=0, fail_got=1.
- Address 9 stuck at 2'b00.
  - err_count=2 (r1 fails in M2, M4).
  - fail_addr=9, fail_exp=3, fail_got=0.
- rst0 asserted at C0+50 for one cycle.
  - Next cycle: csb0=1, web0=1, busy=0, done=0, err_count=0.
  - A new start completes with pass=1 and done at C0'+161.
- start re-pulsed at C0+20 during a run.
  - Ignored: op sequence unchanged, done still at C0+161.
- ERR_W=2, every read forced to wrong data.
  - err_count saturates at 3, pass=0.
  - First fail captured at addr 0 in M1 (exp 0).
